// File: rtl/mdu_pkg.sv
// mdu_pkg -- shared encoding header for the execute stage.
//   ALU op codes (used by the ALU, listed here to keep the encodings together)
//   MDOp codes consumed by the multiply/divide unit (mdu)
//   mag32: operand magnitude helper used when latching operands
package mdu_pkg;

   // ALU operation codes
   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_NOR  = 4'd5;
   localparam logic [3:0] ALU_SLT  = 4'd6;
   localparam logic [3:0] ALU_SLTU = 4'd7;
   localparam logic [3:0] ALU_SLL  = 4'd8;
   localparam logic [3:0] ALU_SRL  = 4'd9;
   localparam logic [3:0] ALU_SRA  = 4'd10;
   localparam logic [3:0] ALU_LUI  = 4'd11;

   // Multiply/divide operation codes; 3'd7 is unassigned and decodes as NOP
   localparam logic [2:0] MD_NOP   = 3'd0;
   localparam logic [2:0] MD_MULT  = 3'd1;
   localparam logic [2:0] MD_MULTU = 3'd2;
   localparam logic [2:0] MD_DIV   = 3'd3;
   localparam logic [2:0] MD_DIVU  = 3'd4;
   localparam logic [2:0] MD_MTHI  = 3'd5;
   localparam logic [2:0] MD_MTLO  = 3'd6;

   // Magnitude of a 32-bit operand. For signed ops a negative value is
   // negated; 32'h80000000 negates to itself, which read as unsigned is
   // exactly 2^31, so no extra bit is needed.
   function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
      return (is_signed && v[31]) ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/mdu_if.sv
// mdu_if -- request/result bundle between the issue logic and the mdu.
//   start, MDOp, A, B : request, sampled on the rising clk edge
//   busy, done, HI, LO : status and architectural HI/LO
//
// Handshake: a request is taken when start=1 at a rising edge while busy=0
// and the unit is idle; start while busy=1 is dropped, never queued. done is
// a one-cycle pulse marking the cycle in which HI/LO first show a
// multiply/divide result. MTHI/MTLO complete at the accepting edge with no
// busy and no done.
interface mdu_if;
   logic               start;
   logic [2:0]         MDOp;
   logic signed [31:0] A;
   logic signed [31:0] B;
   logic               busy;
   logic               done;
   logic [31:0]        HI;
   logic [31:0]        LO;

   modport master (output start, MDOp, A, B, input busy, done, HI, LO);
   modport slave  (input start, MDOp, A, B, output busy, done, HI, LO);
endinterface

// File: rtl/mdu.sv
// mdu -- iterative multiply/divide unit with architectural HI/LO.
//   clk       : clock, rising edge
//   rstn      : asynchronous active-low reset
//   md        : mdu_if.slave (start, MDOp, A, B in; busy, done, HI, LO out)
//   state_dbg : current FSM state (IDLE=0, CALC=1, FIX=2)
// MULT/MULTU run radix-2 shift-add, DIV/DIVU run restoring division, one bit
// per cycle for 32 cycles in CALC, then signs are applied in FIX.
module mdu
   import mdu_pkg::*;
(
   input  logic       clk,
   input  logic       rstn,
   mdu_if.slave       md,
   output logic [1:0] state_dbg
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;

   logic [1:0]  state;
   logic [5:0]  cnt;
   logic [31:0] mag_a;
   logic [31:0] mag_b;
   logic [63:0] acc;
   logic        is_div;
   logic        neg_q;      // product / quotient sign
   logic        neg_r;      // sign of A (remainder sign)
   logic        b_zero;
   logic [31:0] hi_q;
   logic [31:0] lo_q;
   logic        done_q;

   // request decode
   logic op_mul, op_div, op_signed, accept;
   assign op_mul    = (md.MDOp == MD_MULT) || (md.MDOp == MD_MULTU);
   assign op_div    = (md.MDOp == MD_DIV)  || (md.MDOp == MD_DIVU);
   assign op_signed = (md.MDOp == MD_MULT) || (md.MDOp == MD_DIV);
   assign accept    = (state == S_IDLE) && md.start;

   // Shared 64-bit working register acc.
   // Multiply: acc = {partial high, remaining multiplier bits}; add the
   // multiplicand into the top when the low bit is set, then shift right.
   // Divide: acc = {partial remainder, dividend/quotient bits}; shift left
   // by one into a 33-bit trial remainder and keep the subtract if it does
   // not go negative.
   logic [32:0] mul_sum;
   logic [32:0] div_r;
   logic [32:0] div_diff;
   logic [63:0] acc_next;

   always_comb begin
      mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mag_b} : 33'd0);
      div_r    = {acc[63:32], acc[31]};
      div_diff = div_r - {1'b0, mag_b};
      if (is_div) begin
         if (div_diff[32])
            acc_next = {div_r[31:0], acc[30:0], 1'b0};
         else
            acc_next = {div_diff[31:0], acc[30:0], 1'b1};
      end else begin
         acc_next = {mul_sum, acc[31:1]};
      end
   end

   // Sign fix-up for the FIX cycle
   logic [63:0] prod_s;
   logic [31:0] quot_s;
   logic [31:0] rem_s;
   logic [31:0] a_orig;

   always_comb begin
      prod_s = neg_q ? (~acc + 64'd1) : acc;
      quot_s = neg_q ? (~acc[31:0] + 32'd1) : acc[31:0];
      rem_s  = neg_r ? (~acc[63:32] + 32'd1) : acc[63:32];
      // A rebuilt from its magnitude and sign, for the divide-by-zero result
      a_orig = neg_r ? (~mag_a + 32'd1) : mag_a;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state  <= S_IDLE;
         cnt    <= 6'd0;
         mag_a  <= 32'd0;
         mag_b  <= 32'd0;
         acc    <= 64'd0;
         is_div <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         b_zero <= 1'b0;
         hi_q   <= 32'd0;
         lo_q   <= 32'd0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  if (op_mul || op_div) begin
                     state  <= S_CALC;
                     cnt    <= 6'd0;
                     mag_a  <= mag32(md.A, op_signed);
                     mag_b  <= mag32(md.B, op_signed);
                     acc    <= {32'd0, mag32(md.A, op_signed)};
                     is_div <= op_div;
                     neg_q  <= op_signed && (md.A[31] ^ md.B[31]);
                     neg_r  <= op_signed && md.A[31];
                     b_zero <= (md.B == 32'sd0);
                  end else if (md.MDOp == MD_MTHI) begin
                     hi_q <= md.A;
                  end else if (md.MDOp == MD_MTLO) begin
                     lo_q <= md.A;
                  end
               end
            end
            S_CALC: begin
               acc <= acc_next;
               if (cnt == 6'd31) begin
                  state <= S_FIX;
                  cnt   <= 6'd0;
               end else begin
                  cnt <= cnt + 6'd1;
               end
            end
            S_FIX: begin
               state  <= S_IDLE;
               done_q <= 1'b1;
               if (!is_div) begin
                  hi_q <= prod_s[63:32];
                  lo_q <= prod_s[31:0];
               end else if (b_zero) begin
                  hi_q <= a_orig;
                  lo_q <= 32'hFFFF_FFFF;
               end else begin
                  hi_q <= rem_s;
                  lo_q <= quot_s;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign md.busy   = (state == S_CALC) || (state == S_FIX);
   assign md.done   = done_q;
   assign md.HI     = hi_q;
   assign md.LO     = lo_q;
   assign state_dbg = state;

endmodule

// File: tb/tb_mdu.sv
// tb_mdu -- directed self-checking bench for mdu.
module tb_mdu;
   import mdu_pkg::*;

   logic       clk;
   logic       rstn;
   logic [1:0] state_dbg;
   int         checks;
   int         failures;
   logic [63:0] exp_q[$];

   mdu_if ifc ();

   mdu dut (
      .clk       (clk),
      .rstn      (rstn),
      .md        (ifc.slave),
      .state_dbg (state_dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Drive one request at the negedge; returns just after the accepting edge.
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      ifc.start = 1'b1;
      ifc.MDOp  = op;
      ifc.A     = a;
      ifc.B     = b;
      @(posedge clk);
      #1;
      ifc.start = 1'b0;
      ifc.MDOp  = MD_NOP;
   endtask

   // Wait for done, n0 = cycles already elapsed since the accepting edge.
   task automatic wait_done(input string tag, input int n0);
      int n;
      int busy_n;
      logic [63:0] exp;
      n = n0;
      busy_n = 0;
      while (!ifc.done && n < 40) begin
         if (ifc.busy) busy_n++;
         @(posedge clk);
         #1;
         n++;
      end
      check({tag, "_latency"}, 64'(n), 64'd33);
      check({tag, "_busy_cycles"}, 64'(busy_n), 64'(33 - n0));
      check({tag, "_busy_low"}, 64'(ifc.busy), 64'd0);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
      check({tag, "_hilo"}, {ifc.HI, ifc.LO}, exp);
      @(posedge clk);
      #1;
      check({tag, "_done_once"}, 64'(ifc.done), 64'd0);
   endtask

   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
      exp_q.push_back({ehi, elo});
      issue(op, a, b);
      check({tag, "_busy_on"}, 64'(ifc.busy), 64'd1);
      wait_done(tag, 0);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rstn      = 1'b0;
      ifc.start = 1'b0;
      ifc.MDOp  = MD_NOP;
      ifc.A     = '0;
      ifc.B     = '0;

      // reset state
      repeat (2) @(negedge clk);
      check("rst_busy", 64'(ifc.busy), 64'd0);
      check("rst_done", 64'(ifc.done), 64'd0);
      check("rst_hilo", {ifc.HI, ifc.LO}, 64'd0);
      check("rst_state", 64'(state_dbg), 64'd0);
      rstn = 1'b1;

      // multiply / divide vectors
      run_op("mult_m3x7",   MD_MULT,  32'hFFFF_FFFD, 32'd7,          32'hFFFF_FFFF, 32'hFFFF_FFEB);
      run_op("multu_max",   MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001);
      run_op("div_m7d2",    MD_DIV,   32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("divu_by0",    MD_DIVU,  32'd7,         32'd0,          32'd7,         32'hFFFF_FFFF);
      run_op("div_ovf",     MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF,  32'd0,         32'h8000_0000);
      run_op("mult_minsq",  MD_MULT,  32'h8000_0000, 32'h8000_0000,  32'h4000_0000, 32'd0);
      run_op("div_100dm7",  MD_DIV,   32'd100,       32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFF2);
      run_op("div_min_by0", MD_DIV,   32'h8000_0000, 32'd0,          32'h8000_0000, 32'hFFFF_FFFF);

      // MTHI / MTLO while idle
      issue(MD_MTHI, 32'h1234_5678, 32'd0);
      check("mthi_hi", 64'(ifc.HI), 64'h1234_5678);
      check("mthi_lo_kept", 64'(ifc.LO), 64'hFFFF_FFFF);
      check("mthi_busy", 64'(ifc.busy), 64'd0);
      check("mthi_done", 64'(ifc.done), 64'd0);
      issue(MD_MTLO, 32'hCAFE_F00D, 32'd0);
      check("mtlo_lo", 64'(ifc.LO), 64'hCAFE_F00D);
      check("mtlo_hi_kept", 64'(ifc.HI), 64'h1234_5678);

      // unassigned code is a NOP
      issue(3'd7, 32'h5555_5555, 32'd3);
      check("nop_busy", 64'(ifc.busy), 64'd0);
      check("nop_hilo", {ifc.HI, ifc.LO}, 64'h1234_5678_CAFE_F00D);
      @(posedge clk);
      #1;
      check("nop_done", 64'(ifc.done), 64'd0);

      // MTLO during a busy DIV is dropped
      exp_q.push_back({32'd2, 32'd14});
      issue(MD_DIV, 32'd100, 32'd7);
      repeat (4) @(posedge clk);
      @(negedge clk);
      ifc.start = 1'b1;
      ifc.MDOp  = MD_MTLO;
      ifc.A     = 32'hDEAD_BEEF;
      @(posedge clk);
      #1;
      ifc.start = 1'b0;
      ifc.MDOp  = MD_NOP;
      check("busy_mtlo_lo", 64'(ifc.LO), 64'hCAFE_F00D);
      check("busy_mtlo_busy", 64'(ifc.busy), 64'd1);
      wait_done("div_vs_mtlo", 5);

      // reset in the middle of a MULT
      issue(MD_MULT, 32'd3, 32'd4);
      repeat (9) @(posedge clk);
      #2;
      rstn = 1'b0;
      #1;
      check("midrst_busy", 64'(ifc.busy), 64'd0);
      check("midrst_hilo", {ifc.HI, ifc.LO}, 64'd0);
      check("midrst_state", 64'(state_dbg), 64'd0);
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      for (int i = 0; i < 36; i++) begin
         @(posedge clk);
         #1;
         if (ifc.done) check("midrst_no_done", 64'(ifc.done), 64'd0);
      end
      check("midrst_idle", {63'd0, ifc.busy}, 64'd0);
      run_op("multu_5x6", MD_MULTU, 32'd5, 32'd6, 32'd0, 32'd30);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // overall time bound
   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 The block SHALL have a clk input, 1 bit: the single clock, rising edge.
REQ-002 The block SHALL have a rstn input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have a start input, 1 bit: request a new operation, sampled on a rising clk edge.
REQ-004 The block SHALL have an MDOp input, 3 bits: operation code, sampled together with start.
REQ-005 The block SHALL have signed inputs A and B, 32 bits each: operands, sampled together with start.
REQ-006 The block SHALL have a busy output, 1 bit: high while a multiply or divide is in progress.
REQ-007 The block SHALL have a done output, 1 bit: one-cycle pulse when HI/LO receive a multiply or divide result.
REQ-008 The block SHALL have HI and LO outputs, 32 bits each: architectural HI/LO registers, driven directly from flops.

Function
REQ-009 The block SHALL decode MDOp as MULT, MULTU, DIV, DIVU, MTHI and MTLO; every other code SHALL be a NOP that leaves HI/LO unchanged and asserts neither busy nor done.
REQ-010 The block SHALL accept start only in IDLE; start while busy=1 SHALL be ignored, with no queuing and no effect on the operation in flight.
REQ-011 MTHI SHALL write HI=A, and MTLO SHALL write LO=A, at the accepting edge; these take one cycle, with no busy and no done.
REQ-012 The FSM SHALL have three states: IDLE, CALC and FIX. IDLE goes to CALC on an accepted MULT/MULTU/DIV/DIVU. CALC goes to FIX after exactly 32 iterations (6-bit counter 0..31). FIX goes to IDLE unconditionally.
REQ-013 busy SHALL be high in CALC and FIX, and low otherwise.
REQ-014 On accept, the block SHALL latch operand magnitudes: the absolute value for signed ops, the raw value for unsigned ops. It SHALL also latch the result signs.
REQ-015 Multiply SHALL use radix-2 shift-add, one bit per cycle, with a 64-bit accumulator.
REQ-016 Divide SHALL use restoring division, one quotient bit per cycle, with a 33-bit partial-remainder subtract.
REQ-017 In FIX the block SHALL apply signs, then write HI/LO.
REQ-018 In FIX, the product sign SHALL be sign(A) xor sign(B).
REQ-019 In FIX, the quotient sign SHALL be sign(A) xor sign(B), and the remainder SHALL take the sign of A.
REQ-020 In FIX the block SHALL pulse done=1 for exactly one cycle.
REQ-021 Latency: with start accepted at edge E0, HI/LO and done SHALL become valid after edge E33, and busy SHALL fall after E33.
REQ-022 MULT/MULTU results SHALL be HI = product[63:32] and LO = product[31:0].
REQ-023 DIV/DIVU results SHALL be LO = quotient and HI = remainder, truncated toward zero.
REQ-024 Divide by zero (B=0) SHALL give LO=32'hFFFFFFFF and HI=A, with the normal 33-cycle latency.
REQ-025 Signed overflow, DIV with A=32'h80000000 and B=32'hFFFFFFFF, SHALL give LO=32'h80000000 and HI=0.
REQ-026 The absolute value of 32'h80000000 SHALL be handled as an unsigned 2^31, with no overflow.
REQ-027 HI/LO SHALL hold their values in every cycle except MTHI, MTLO and FIX.
REQ-028 start asserted in the same cycle as FIX SHALL be ignored; the block accepts new work in the cycle after done.

Reset
REQ-029 On rstn=0 the block SHALL immediately force state=IDLE, busy=0, done=0, HI=0, LO=0 and counter=0, and clear all working registers.
REQ-030 Reset mid-operation SHALL abort the operation with no done pulse, and HI/LO SHALL read 0.
REQ-031 Release of rstn SHALL take effect at the next clk edge, and a start coincident with that edge SHALL be accepted.

Structure
REQ-032 The MDOp codes (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO, MD_NOP) SHALL be defined in the shared encoding header, alongside the ALU op codes.
REQ-033 The FSM state encodings SHALL be local to the module.
REQ-034 The block SHALL be a single module with no sub-module; the multiply and divide datapaths share the operand and counter registers.

Verification
REQ-035 The bench SHALL drive MULT with A=-3 and B=7 and check HI=32'hFFFFFFFF, LO=32'hFFFFFFEB, done pulsed once 33 cycles after accept, and busy=1 for 33 cycles.
REQ-036 The bench SHALL drive MULTU with A=B=32'hFFFFFFFF and check HI=32'hFFFFFFFE and LO=32'h00000001.
REQ-037 The bench SHALL drive DIV with A=-7 and B=2 and check LO=32'hFFFFFFFD (-3) and HI=32'hFFFFFFFF (-1); DIVU with A=7 and B=0 SHALL give LO=32'hFFFFFFFF and HI=7.
REQ-038 The bench SHALL drive DIV with A=32'h80000000 and B=-1 and check LO=32'h80000000 and HI=0.
REQ-039 The bench SHALL issue MTHI with A=32'h12345678 while idle and check HI updated next cycle with no busy; it SHALL then issue MTLO during a busy DIV and check that it is ignored and that only the DIV result lands.
REQ-040 The bench SHALL pull rstn low at cycle 10 of a MULT and check busy=0 and HI=LO=0 immediately, with no done pulse; it SHALL then issue a new MULTU of 5 and 6 after release and check LO=30.
